// File: rtl/venus_core.sv
// venus_core: three-stage (IF/ID/EX) 16-bit processor with a synchronous instruction ROM,
// a 16x16 register file carrying per-register reservation bits, and a flag-setting execute stage.
module venus_core #(
  parameter string       IMEM_FILE = "prog.hex",
  parameter int unsigned IMEM_AW   = 8
) (
  input logic clk,
  input logic rst
);

  localparam int unsigned DW         = 16;
  localparam int unsigned RN         = 16;
  localparam int unsigned IMEM_DEPTH = 1 << IMEM_AW;

  localparam logic [3:0] OPC_ALU  = 4'd1;
  localparam logic [3:0] OPC_LDI  = 4'd2;
  localparam logic [3:0] OPC_ADDI = 4'd3;
  localparam logic [3:0] OPC_JCC  = 4'd4;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_SHR = 4'd6;
  localparam logic [3:0] ALU_CMP = 4'd8;

  // status_r bit positions: {V,C,N,Z}
  localparam int unsigned FZ = 0;
  localparam int unsigned FN = 1;
  localparam int unsigned FC = 2;
  localparam int unsigned FV = 3;

  // ---------------- fetch ----------------
  logic [IMEM_AW-1:0] pc;
  logic [IMEM_AW-1:0] addr_ifmem;
  logic [DW-1:0]      imem [0:IMEM_DEPTH-1];
  logic [DW-1:0]      inst_memid;
  logic [IMEM_AW-1:0] origaddr_memid;
  logic               v_ifid;

  // ---------------- decode ----------------
  logic [3:0]    opc_id;
  logic [3:0]    dopc_id;
  logic [3:0]    rd_name;
  logic [3:0]    rs_name;
  logic [DW-1:0] imm_sext;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] rs_data;
  logic          rd_reserved;
  logic          rs_reserved;
  logic          id_writes;
  logic          id_uses_rd;
  logic          id_uses_rs;
  logic          id_issue;
  logic          rd_reserve;
  logic          stall_idif;

  logic [DW-1:0] regs [RN];
  logic [RN-1:0] resv;
  logic [RN-1:0] resv_nx;

  // ---------------- ID/EX ----------------
  logic               v_idex;
  logic [DW-1:0]      src_idex;
  logic [DW-1:0]      dest_idex;
  logic [3:0]         cc_idex;
  logic [3:0]         rdname_idex;
  logic               wb_idex;
  logic [3:0]         dopc_idex;
  logic [3:0]         opc_idex;
  logic [IMEM_AW-1:0] origaddr_idex;

  // ---------------- execute ----------------
  logic [DW:0]        add_sum;
  logic [DW:0]        sub_dif;
  logic               add_ovf;
  logic               sub_ovf;
  logic [DW-1:0]      actual_data;
  logic               carry;
  logic               ovf;
  logic               flag_op;
  logic [3:0]         status_r;
  logic [3:0]         status_nx;
  logic               cond_true;
  logic [IMEM_AW-1:0] jump_data;
  logic               branch_i;
  logic [IMEM_AW-1:0] baddr_i;
  logic               stall_exid;
  logic               wb_exreg;
  logic [3:0]         wb_rd_name_exreg;
  logic [DW-1:0]      wb_rd_data_exreg;

  assign addr_ifmem = pc;

  // PC and registered ROM output; a taken branch redirects and voids the word in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc             <= '0;
      v_ifid         <= 1'b0;
      inst_memid     <= '0;
      origaddr_memid <= '0;
    end else if (branch_i) begin
      pc     <= baddr_i;
      v_ifid <= 1'b0;
    end else if (!stall_idif) begin
      pc             <= pc + IMEM_AW'(1);
      v_ifid         <= 1'b1;
      inst_memid     <= imem[addr_ifmem];
      origaddr_memid <= addr_ifmem;
    end
  end

  assign opc_id   = inst_memid[15:12];
  assign rd_name  = inst_memid[11:8];
  assign rs_name  = inst_memid[7:4];
  assign dopc_id  = inst_memid[3:0];
  assign imm_sext = {{8{inst_memid[7]}}, inst_memid[7:0]};

  assign rd_data     = regs[rd_name];
  assign rs_data     = regs[rs_name];
  assign rd_reserved = resv[rd_name];
  assign rs_reserved = resv[rs_name];

  assign id_writes  = ((opc_id == OPC_ALU) && (dopc_id != ALU_CMP)) ||
                      (opc_id == OPC_LDI) || (opc_id == OPC_ADDI);
  assign id_uses_rd = (opc_id == OPC_ALU) || (opc_id == OPC_LDI) || (opc_id == OPC_ADDI);
  assign id_uses_rs = (opc_id == OPC_ALU);

  // Jcc and NOP carry no register operands, so their rd/rs fields never cause a stall
  assign stall_idif = v_ifid & ((id_uses_rd & rd_reserved) | (id_uses_rs & rs_reserved));
  assign id_issue   = v_ifid & ~stall_idif & ~stall_exid;
  assign rd_reserve = id_issue & id_writes;

  // ID/EX pipeline register; a stall or squash inserts a bubble
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_idex        <= 1'b0;
      src_idex      <= '0;
      dest_idex     <= '0;
      cc_idex       <= '0;
      rdname_idex   <= '0;
      wb_idex       <= 1'b0;
      dopc_idex     <= '0;
      opc_idex      <= '0;
      origaddr_idex <= '0;
    end else begin
      v_idex <= id_issue;
      if (id_issue) begin
        src_idex      <= (opc_id == OPC_ALU) ? rs_data : imm_sext;
        dest_idex     <= rd_data;
        cc_idex       <= rd_name;
        rdname_idex   <= rd_name;
        wb_idex       <= id_writes;
        dopc_idex     <= dopc_id;
        opc_idex      <= opc_id;
        origaddr_idex <= origaddr_memid;
      end
    end
  end

  assign add_sum = {1'b0, dest_idex} + {1'b0, src_idex};
  assign sub_dif = {1'b0, dest_idex} - {1'b0, src_idex};
  assign add_ovf = (dest_idex[DW-1] == src_idex[DW-1]) && (add_sum[DW-1] != dest_idex[DW-1]);
  assign sub_ovf = (dest_idex[DW-1] != src_idex[DW-1]) && (sub_dif[DW-1] != dest_idex[DW-1]);

  // Execute datapath; sub_dif[DW] is the borrow out of the subtraction
  always_comb begin
    actual_data = src_idex;
    carry       = 1'b0;
    ovf         = 1'b0;
    flag_op     = 1'b0;
    case (opc_idex)
      OPC_ALU: begin
        flag_op = 1'b1;
        case (dopc_idex)
          ALU_ADD: begin
            actual_data = add_sum[DW-1:0];
            carry       = add_sum[DW];
            ovf         = add_ovf;
          end
          ALU_SUB, ALU_CMP: begin
            actual_data = sub_dif[DW-1:0];
            carry       = sub_dif[DW];
            ovf         = sub_ovf;
          end
          ALU_AND: actual_data = dest_idex & src_idex;
          ALU_OR:  actual_data = dest_idex | src_idex;
          ALU_XOR: actual_data = dest_idex ^ src_idex;
          ALU_SHL: actual_data = dest_idex << src_idex[3:0];
          ALU_SHR: actual_data = dest_idex >> src_idex[3:0];
          default: actual_data = src_idex;
        endcase
      end
      OPC_ADDI: begin
        flag_op     = 1'b1;
        actual_data = add_sum[DW-1:0];
        carry       = add_sum[DW];
        ovf         = add_ovf;
      end
      default: actual_data = src_idex;
    endcase
  end

  assign status_nx = {ovf, carry, actual_data[DW-1], (actual_data == '0)};

  // Branch condition evaluation against the committed flags
  always_comb begin
    cond_true = 1'b0;
    case (cc_idex)
      4'd0:    cond_true = 1'b1;
      4'd1:    cond_true = status_r[FZ];
      4'd2:    cond_true = ~status_r[FZ];
      4'd3:    cond_true = status_r[FN];
      4'd4:    cond_true = ~status_r[FN];
      4'd5:    cond_true = status_r[FC];
      4'd6:    cond_true = ~status_r[FC];
      4'd7:    cond_true = status_r[FV];
      4'd8:    cond_true = ~status_r[FV];
      default: cond_true = 1'b0;
    endcase
  end

  assign jump_data  = origaddr_idex + IMEM_AW'(src_idex);
  assign branch_i   = v_idex & (opc_idex == OPC_JCC) & cond_true;
  assign baddr_i    = jump_data;
  assign stall_exid = branch_i;

  assign wb_exreg         = v_idex & wb_idex;
  assign wb_rd_name_exreg = rdname_idex;
  assign wb_rd_data_exreg = actual_data;

  // Writeback clears a reservation at the same edge an issuing instruction may set one
  always_comb begin
    resv_nx = resv;
    if (wb_exreg) resv_nx[wb_rd_name_exreg] = 1'b0;
    if (rd_reserve) resv_nx[rd_name] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(RN); i++) regs[i] <= '0;
      resv     <= '0;
      status_r <= '0;
    end else begin
      if (wb_exreg) regs[wb_rd_name_exreg] <= wb_rd_data_exreg;
      if (v_idex && flag_op) status_r <= status_nx;
      resv <= resv_nx;
    end
  end

endmodule

// File: tb/tb_venus_core.sv
// Bench for venus_core: directed programs plus random programs compared against an
// instruction-level model of the ISA (architectural registers and flags).
`timescale 1ns/1ps
module tb_venus_core;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [15:0] prog [256];
  logic [15:0] m_regs [16];
  logic [3:0]  m_st;
  int stall_cnt [256];
  int exec_cnt  [256];
  int br_cnt    [256];

  venus_core #(.IMEM_FILE(""), .IMEM_AW(8)) dut (.clk(clk), .rst(rst));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-address event counters, sampled at the edge that closes each cycle
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) begin
        stall_cnt[i] = 0;
        exec_cnt[i]  = 0;
        br_cnt[i]    = 0;
      end
    end else begin
      if (dut.stall_idif) stall_cnt[dut.origaddr_memid] += 1;
      if (dut.v_idex)     exec_cnt[dut.origaddr_idex]   += 1;
      if (dut.branch_i)   br_cnt[dut.origaddr_idex]     += 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
  endtask

  // Load the ROM under reset, then release; returns at cycle 0 (first cycle after the reset edge)
  task automatic start_prog();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) dut.imem[i] = prog[i];
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_exec(input int addr, input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 500 && !got; n++) begin
      @(negedge clk);
      if (dut.v_idex && dut.origaddr_idex == 8'(addr)) got = 1'b1;
    end
    chk({tag, " reached"}, 32'(got), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_halt(input int halt, input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if (dut.branch_i && dut.origaddr_idex == 8'(halt)) got = 1'b1;
    end
    chk({tag, " halt reached"}, 32'(got), 32'd1);
  endtask

  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] st);
    case (cc)
      4'd0: return 1'b1;
      4'd1: return st[0];
      4'd2: return !st[0];
      4'd3: return st[1];
      4'd4: return !st[1];
      4'd5: return st[2];
      4'd6: return !st[2];
      4'd7: return st[3];
      4'd8: return !st[3];
      default: return 1'b0;
    endcase
  endfunction

  // Sequential interpreter: one instruction at a time, integer arithmetic for carry/overflow
  task automatic model_run(input int halt);
    int pc, nxt, steps, ua, ub, sr;
    logic [15:0] ins, a, b, r;
    logic c, v, flg, wr;
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    m_st = 4'h0;
    pc = 0;
    steps = 0;
    while (pc != halt && steps < 5000) begin
      ins = prog[pc];
      a   = m_regs[ins[11:8]];
      b   = (ins[15:12] == 4'd1) ? m_regs[ins[7:4]] : {{8{ins[7]}}, ins[7:0]};
      ua  = int'(a);
      ub  = int'(b);
      r = b; c = 1'b0; v = 1'b0; flg = 1'b0; wr = 1'b0;
      nxt = pc + 1;
      case (ins[15:12])
        4'd1: begin
          flg = 1'b1;
          wr  = (ins[3:0] != 4'd8);
          case (ins[3:0])
            4'd0: begin
              r = 16'(ua + ub); c = (ua + ub) > 65535;
              sr = int'($signed(a)) + int'($signed(b)); v = (sr > 32767) || (sr < -32768);
            end
            4'd1, 4'd8: begin
              r = 16'(ua - ub); c = ua < ub;
              sr = int'($signed(a)) - int'($signed(b)); v = (sr > 32767) || (sr < -32768);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b[3:0];
            4'd6: r = a >> b[3:0];
            default: r = b;
          endcase
        end
        4'd2: wr = 1'b1;
        4'd3: begin
          flg = 1'b1; wr = 1'b1;
          r = 16'(ua + ub); c = (ua + ub) > 65535;
          sr = int'($signed(a)) + int'($signed(b)); v = (sr > 32767) || (sr < -32768);
        end
        4'd4: if (cond_ok(ins[11:8], m_st)) nxt = (pc + int'($signed(ins[7:0]))) & 255;
        default: ;
      endcase
      if (wr) m_regs[ins[11:8]] = r;
      if (flg) m_st = {v, c, r[15], (r == 16'h0)};
      pc = nxt;
      steps++;
    end
  endtask

  task automatic check_arch(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s r%0d", tag, i), 32'(dut.regs[i]), 32'(m_regs[i]));
    chk({tag, " status"}, 32'(dut.status_r), 32'(m_st));
    chk({tag, " reservations idle"}, 32'(dut.resv), 32'd0);
  endtask

  task automatic gen_random(input int len);
    int k, imm;
    logic [3:0] rd, rs;
    clear_prog();
    for (int i = 0; i < len; i++) begin
      k  = $urandom_range(0, 9);
      rd = 4'($urandom_range(0, 7));
      rs = 4'($urandom_range(0, 7));
      case (k)
        0, 1:    prog[i] = {4'd2, rd, 8'($urandom)};
        2, 3, 4: prog[i] = {4'd1, rd, rs, 4'($urandom)};
        5, 6:    prog[i] = {4'd3, rd, 8'($urandom)};
        7: begin
          k = $urandom_range(4, 15);
          if (k == 4) k = 0;
          prog[i] = {4'(k), 12'($urandom)};
        end
        default: begin
          imm = $urandom_range(1, 3);
          if (i + imm > len) imm = len - i;
          prog[i] = {4'd4, 4'($urandom_range(0, 15)), 8'(imm)};
        end
      endcase
    end
    prog[len] = 16'h4000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;

    // ---- program A: reset/first fetch, independent LDIs, RAW stall, flags ----
    clear_prog();
    prog[0]  = 16'h2105; // LDI r1,5
    prog[1]  = 16'h22FD; // LDI r2,-3
    prog[2]  = 16'h2607; // LDI r6,7
    prog[3]  = 16'h1660; // ADD r6,r6
    prog[4]  = 16'h2301; // LDI r3,1
    prog[5]  = 16'h2401; // LDI r4,1
    prog[6]  = 16'h1348; // CMP r3,r4
    prog[7]  = 16'h257F; // LDI r5,0x7f
    prog[8]  = 16'h2708; // LDI r7,8
    prog[9]  = 16'h1575; // SHL r5,r7 -> 7f00
    prog[10] = 16'h357F; // ADDI r5,0x7f
    prog[11] = 16'h357F; // ADDI r5,0x7f -> 7ffe
    prog[12] = 16'h3501; // ADDI r5,1 -> 7fff
    prog[13] = 16'h3501; // ADDI r5,1 -> 8000
    prog[14] = 16'h4000; // halt
    start_prog();
    chk("c0 addr_ifmem", 32'(dut.addr_ifmem), 32'd0);
    chk("c0 v_ifid", 32'(dut.v_ifid), 32'd0);
    chk("c0 v_idex", 32'(dut.v_idex), 32'd0);
    chk("c0 branch_i", 32'(dut.branch_i), 32'd0);
    chk("c0 stalls", 32'({dut.stall_idif, dut.stall_exid}), 32'd0);
    chk("c0 wb_exreg", 32'(dut.wb_exreg), 32'd0);
    chk("c0 status", 32'(dut.status_r), 32'd0);
    chk("c0 resv", 32'(dut.resv), 32'd0);
    @(negedge clk);
    chk("c1 addr_ifmem", 32'(dut.addr_ifmem), 32'd1);
    chk("c1 v_ifid", 32'(dut.v_ifid), 32'd1);
    chk("c1 v_idex", 32'(dut.v_idex), 32'd0);
    @(negedge clk);
    chk("c2 addr_ifmem", 32'(dut.addr_ifmem), 32'd2);
    chk("c2 v_idex", 32'(dut.v_idex), 32'd1);
    chk("c2 origaddr_idex", 32'(dut.origaddr_idex), 32'd0);
    wait_exec(3, "A add");
    chk("A r6 after add", 32'(dut.regs[6]), 32'h000e);
    chk("A status after add", 32'(dut.status_r), 32'h0);
    wait_exec(6, "A cmp");
    chk("A status after cmp", 32'(dut.status_r), 32'h1);
    chk("A r3 after cmp", 32'(dut.regs[3]), 32'h0001);
    wait_exec(11, "A addi x2");
    chk("A r5 after addi x2", 32'(dut.regs[5]), 32'h7ffe);
    chk("A status no V", 32'(dut.status_r), 32'h0);
    wait_exec(13, "A 7fff+1");
    chk("A r5 8000", 32'(dut.regs[5]), 32'h8000);
    chk("A status V N", 32'(dut.status_r), 32'hA);
    wait_halt(14, "A");
    chk("A r1", 32'(dut.regs[1]), 32'h0005);
    chk("A r2", 32'(dut.regs[2]), 32'hfffd);
    chk("A raw stall count", 32'(stall_cnt[3]), 32'd1);
    chk("A ldi no stall", 32'(stall_cnt[1]), 32'd0);
    model_run(14);
    check_arch("A");

    // ---- program B: counted loop with a conditional backward branch ----
    clear_prog();
    prog[0] = 16'h2203; // LDI r2,3
    prog[1] = 16'h2100; // LDI r1,0
    prog[2] = 16'h3101; // ADDI r1,1
    prog[3] = 16'h1128; // CMP r1,r2
    prog[4] = 16'h42FE; // J!Z -2
    prog[5] = 16'h4000; // halt
    start_prog();
    begin
      bit got;
      got = 1'b0;
      for (int n = 0; n < 200 && !got; n++) begin
        @(negedge clk);
        if (dut.branch_i && dut.origaddr_idex == 8'd4) got = 1'b1;
      end
      chk("B first branch seen", 32'(got), 32'd1);
      chk("B stall_exid", 32'(dut.stall_exid), 32'd1);
      chk("B baddr_i", 32'(dut.baddr_i), 32'd2);
      @(negedge clk);
      chk("B bubble 1", 32'(dut.v_idex), 32'd0);
      @(negedge clk);
      chk("B bubble 2", 32'(dut.v_idex), 32'd0);
      @(negedge clk);
      chk("B target in EX", 32'({dut.v_idex, dut.origaddr_idex}), 32'h102);
    end
    wait_halt(5, "B");
    chk("B r1", 32'(dut.regs[1]), 32'h0003);
    chk("B loop body runs", 32'(exec_cnt[2]), 32'd3);
    chk("B taken jumps", 32'(br_cnt[4]), 32'd2);
    model_run(5);
    check_arch("B");

    // ---- mid-run reset during the loop ----
    start_prog();
    repeat (10) @(negedge clk);
    chk("R r2 before reset", 32'(dut.regs[2]), 32'h0003);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++)
      chk($sformatf("R r%0d cleared", i), 32'(dut.regs[i]), 32'd0);
    chk("R status", 32'(dut.status_r), 32'd0);
    chk("R pc", 32'(dut.addr_ifmem), 32'd0);
    chk("R valids", 32'({dut.v_ifid, dut.v_idex}), 32'd0);
    chk("R resv", 32'(dut.resv), 32'd0);
    rst = 1'b1;
    wait_halt(5, "R");
    chk("R r1 after rerun", 32'(dut.regs[1]), 32'h0003);

    // ---- random programs against the model ----
    for (int t = 0; t < 6; t++) begin
      gen_random(24);
      start_prog();
      wait_halt(24, $sformatf("rand%0d", t));
      model_run(24);
      check_arch($sformatf("rand%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
